// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first.
// A word is captured on an accepted load (load=1 while ready=1). One data bit
// is then driven per cycle, followed by a one-cycle done pulse back in IDLE.
// Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit
// (PAR state) after the data bits. The port list is identical in both builds.
// Reset clr is asynchronous and active-high.
module piso_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // Counter only has to reach WIDTH-1, so it never wraps inside a frame.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef PISO_TX_PARITY_EN
    localparam logic [1:0] PAR   = 2'd2;
`endif

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic [CW-1:0]    cnt_reg;
    logic             sout_reg;
    logic             busy_reg;
    logic             done_reg;
`ifdef PISO_TX_PARITY_EN
    logic             par_reg;
`endif

    // ready is a pure decode of the state register so a load can be taken
    // in the very cycle the done pulse is shown.
    assign ready = (state_reg == IDLE);
    assign sout  = sout_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;

`ifdef PISO_TX_PARITY_EN
    // Parity accumulator: latched once at accept so later din changes cannot
    // corrupt the trailing bit.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            par_reg <= 1'b0;
        end else if (state_reg == IDLE && load) begin
            par_reg <= ^din;
        end
    end
`endif

    // Frame sequencer: state, shift register, bit counter and the registered
    // serial/status outputs all advance together.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            sout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless re-asserted below.
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        // Bit 0 goes out on the accepting edge itself.
                        state_reg <= SHIFT;
                        sout_reg  <= din[0];
                        shreg_reg <= din >> 1;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end else begin
                        sout_reg  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_reg == LAST_BIT) begin
`ifdef PISO_TX_PARITY_EN
                        state_reg <= PAR;
                        sout_reg  <= par_reg;
`else
                        state_reg <= IDLE;
                        sout_reg  <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                        sout_reg  <= shreg_reg[0];
                        shreg_reg <= shreg_reg >> 1;
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PAR: begin
                    state_reg <= IDLE;
                    sout_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
`endif
                default: begin
                    // Unreachable encodings fall back to a quiet IDLE.
                    state_reg <= IDLE;
                    sout_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx (WIDTH=8).
// Build with PISO_TX_PARITY_EN defined to cover the parity variant as well.
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] din;
    logic       load;
    logic       ready;
    logic       sout;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    piso_tx #(.WIDTH(8)) dut (
        .clk   (clk),
        .clr   (clr),
        .din   (din),
        .load  (load),
        .ready (ready),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; load = 1'b0; din = 8'h00;
        #3;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL reset_sout: got %b expected 0", sout); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        // load must be ignored while clr is held
        load = 1'b1; din = 8'hFF;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_load_ignored_busy: got %b expected 0", busy); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_load_ignored_ready: got %b expected 1", ready); end
        load = 1'b0; clr = 1'b0;
        tick();
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL idle_sout: got %b expected 0", sout); end
        $display("reset: done");
    endtask

    task automatic test_basic_a5();
        logic [7:0] w;
        w = 8'hA5;
        din = w; load = 1'b1;
        tick();
        load = 1'b0; din = 8'h00;   // later din changes must not matter
        n_cmp++; if (sout !== w[0]) begin n_bad++; $display("FAIL a5_bit0: got %b expected %b", sout, w[0]); end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL a5_ready: got %b expected 0", ready); end
        for (int k = 1; k < 8; k++) begin
            tick();
            n_cmp++; if (sout !== w[k]) begin n_bad++; $display("FAIL a5_bit%0d: got %b expected %b", k, sout, w[k]); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL a5_busy%0d: got %b expected 1", k, busy); end
        end
`ifdef PISO_TX_PARITY_EN
        tick();
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL a5_parity: got %b expected 0", sout); end
`endif
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL a5_done: got %b expected 1", done); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL a5_done_ready: got %b expected 1", ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_done_busy: got %b expected 0", busy); end
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL a5_done_sout: got %b expected 0", sout); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL a5_done_clear: got %b expected 0", done); end
        $display("frame A5: done");
    endtask

`ifdef PISO_TX_PARITY_EN
    task automatic test_parity_07();
        logic [7:0] w;
        int edges;
        w = 8'h07;
        din = w; load = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++; if (sout !== 1'b1) begin n_bad++; $display("FAIL p07_bit0: got %b expected 1", sout); end
        for (int k = 1; k < 8; k++) begin
            tick();
            n_cmp++; if (sout !== w[k]) begin n_bad++; $display("FAIL p07_bit%0d: got %b expected %b", k, sout, w[k]); end
        end
        tick();
        n_cmp++; if (sout !== 1'b1) begin n_bad++; $display("FAIL p07_parity: got %b expected 1", sout); end
        edges = 9;
        tick();
        edges++;
        // accepting edge counted as cycle 1, done seen after cycle 10
        n_cmp++; if (done !== 1'b1 || edges != 10) begin n_bad++; $display("FAIL p07_done: got done=%b at %0d expected done=1 at 10", done, edges); end
        tick();
        $display("frame 07 with parity: done");
    endtask
`endif

    task automatic test_ignore_busy();
        din = 8'hFF; load = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++; if (sout !== 1'b1) begin n_bad++; $display("FAIL ff_bit0: got %b expected 1", sout); end
        for (int k = 1; k < 8; k++) begin
            if (k == 3) begin din = 8'h00; load = 1'b1; end
            tick();
            load = 1'b0;
            n_cmp++; if (sout !== 1'b1) begin n_bad++; $display("FAIL ff_bit%0d: got %b expected 1", k, sout); end
            n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ff_busy%0d: got %b expected 1", k, busy); end
        end
`ifdef PISO_TX_PARITY_EN
        tick();
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL ff_parity: got %b expected 0", sout); end
`endif
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ff_done: got %b expected 1", done); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ff_idle_busy: got %b expected 0", busy); end
        $display("frame FF with ignored load: done");
    endtask

    task automatic test_abort();
        logic [7:0] w;
        int dpulses;
        din = 8'h3C; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();  // bit 4 now on sout
        n_cmp++; if (sout !== 1'b1) begin n_bad++; $display("FAIL abort_bit4: got %b expected 1", sout); end
        #1 clr = 1'b1;
        #1;
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL abort_sout: got %b expected 0", sout); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b expected 1", ready); end
        tick();
        #1 clr = 1'b0;
        dpulses = 0;
        repeat (6) begin
            tick();
            if (done === 1'b1) dpulses++;
        end
        n_cmp++; if (dpulses != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d pulses expected 0", dpulses); end
        w = 8'h81;
        din = w; load = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++; if (sout !== w[0]) begin n_bad++; $display("FAIL r81_bit0: got %b expected %b", sout, w[0]); end
        for (int k = 1; k < 8; k++) begin
            tick();
            n_cmp++; if (sout !== w[k]) begin n_bad++; $display("FAIL r81_bit%0d: got %b expected %b", k, sout, w[k]); end
        end
`ifdef PISO_TX_PARITY_EN
        tick();
`endif
        tick();
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL r81_done: got %b expected 1", done); end
        tick();
        $display("abort 3C then frame 81: done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        int dpulses;
        a = 8'h55; b = 8'hAA;
        dpulses = 0;
        din = a; load = 1'b1;
        tick();
        din = b;            // load stays high through the whole first frame
        n_cmp++; if (sout !== a[0]) begin n_bad++; $display("FAIL b2b_a_bit0: got %b expected %b", sout, a[0]); end
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done === 1'b1) dpulses++;
            n_cmp++; if (sout !== a[k]) begin n_bad++; $display("FAIL b2b_a_bit%0d: got %b expected %b", k, sout, a[k]); end
        end
`ifdef PISO_TX_PARITY_EN
        tick();
        if (done === 1'b1) dpulses++;
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL b2b_a_parity: got %b expected 0", sout); end
`endif
        tick();
        if (done === 1'b1) dpulses++;
        n_cmp++; if (done !== 1'b1 || ready !== 1'b1) begin n_bad++; $display("FAIL b2b_a_done: got done=%b ready=%b expected 1 1", done, ready); end
        tick();
        if (done === 1'b1) dpulses++;
        load = 1'b0;
        n_cmp++; if (sout !== b[0] || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_b_bit0: got sout=%b busy=%b expected %b 1", sout, busy, b[0]); end
        for (int k = 1; k < 8; k++) begin
            tick();
            if (done === 1'b1) dpulses++;
            n_cmp++; if (sout !== b[k]) begin n_bad++; $display("FAIL b2b_b_bit%0d: got %b expected %b", k, sout, b[k]); end
        end
`ifdef PISO_TX_PARITY_EN
        tick();
        if (done === 1'b1) dpulses++;
        n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL b2b_b_parity: got %b expected 0", sout); end
`endif
        tick();
        if (done === 1'b1) dpulses++;
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_b_done: got %b expected 1", done); end
        repeat (3) begin
            tick();
            if (done === 1'b1) dpulses++;
        end
        n_cmp++; if (dpulses != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d expected 2", dpulses); end
        $display("back-to-back 55/AA: done");
    endtask

    task automatic test_receiver();
        logic [7:0] w;
        logic [7:0] rx;
        int errs;
        errs = 0;
        rx = 8'h00;
        for (int i = 0; i < 256; i++) begin
            w = 8'(i) ^ 8'h5A;
            din = w; load = 1'b1;
            tick();
            load = 1'b0; din = ~w;
            rx = {sout, rx[7:1]};
            repeat (7) begin
                tick();
                rx = {sout, rx[7:1]};
            end
            n_cmp++;
            if (rx !== w) begin
                n_bad++; errs++;
                $display("FAIL rx_word%0d: got %h expected %h", i, rx, w);
            end
`ifdef PISO_TX_PARITY_EN
            tick();
`endif
            tick();     // done cycle; next load is taken on the following edge
        end
        $display("receiver 256 words: %0d errors", errs);
    endtask

    initial begin
        test_reset();
        test_basic_a5();
`ifdef PISO_TX_PARITY_EN
        test_parity_07();
`endif
        test_ignore_busy();
        test_abort();
        test_back_to_back();
        test_receiver();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
